if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS R2000 pipeline, directly upstream of the decode stage (ID).
- Owns the program counter and drives the instruction-memory address.
- Contains the IF/ID pipeline register that feeds ID's instruction input.
- Handles stalls, redirects for branches, jumps and exceptions, and flushes, while preserving MIPS branch-delay-slot semantics.

---
 rtl/if_stage.sv | 80 ++++++++
 tb/tb_if_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS R2000 instruction-fetch stage with PC, pending redirect and IF/ID register
// Redirects never flush: the word in flight when a redirect arrives is the delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic        valid_out
);

    logic [31:0] r_pc;
    logic        r_pend_v;
    logic [31:0] r_pend_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic [31:0] w_inc;
    logic [31:0] w_target;

    assign w_inc    = r_pc + 32'd4;
    assign w_target = {redirect_pc_in[31:2], 2'b00};

    // A redirect seen during a stall is parked so the delay slot still issues first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pend_v  <= 1'b0;
            r_pend_pc <= 32'h0000_0000;
        end else if (redirect_in) begin
            if (!stall_in) begin
                r_pc     <= w_target;
                r_pend_v <= 1'b0;
            end else begin
                r_pend_v  <= 1'b1;
                r_pend_pc <= w_target;
            end
        end else if (r_pend_v && !stall_in) begin
            r_pc     <= r_pend_pc;
            r_pend_v <= 1'b0;
        end else if (!stall_in) begin
            r_pc <= w_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst   <= NOP_INST;
            r_pc_out <= 32'h0000_0000;
            r_pc4    <= 32'h0000_0000;
            r_valid  <= 1'b0;
        end else if (flush_in) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (!stall_in) begin
            r_inst   <= imem_rdata_in;
            r_pc_out <= r_pc;
            r_pc4    <= w_inc;
            r_valid  <= 1'b1;
        end
    end

    assign imem_addr_out = r_pc;
    assign inst_out      = r_inst;
    assign pc_out        = r_pc_out;
    assign pc4_out       = r_pc4;
    assign valid_out     = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .imem_addr_out(imem_addr_out), .imem_rdata_in(imem_rdata_in),
        .inst_out(inst_out), .pc_out(pc_out), .pc4_out(pc4_out), .valid_out(valid_out)
    );

    assign imem_rdata_in = imem_addr_out ^ XORV;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (inst_out !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h exp %h", inst_out, 32'h0); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h exp %h", pc_out, 32'h0); end
        n_cmp++; if (pc4_out !== 32'h0) begin n_bad++; $display("FAIL rst_pc4: got %h exp %h", pc4_out, 32'h0); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b exp 0", valid_out); end
        n_cmp++; if (imem_addr_out !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h exp %h", imem_addr_out, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'(i) * 32'd4;
            step();
            n_cmp++; if (pc_out !== pc) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, pc_out, pc); end
            n_cmp++; if (inst_out !== (pc ^ XORV)) begin n_bad++; $display("FAIL seq_inst[%0d]: got %h exp %h", i, inst_out, pc ^ XORV); end
            n_cmp++; if (pc4_out !== pc + 32'd4) begin n_bad++; $display("FAIL seq_pc4[%0d]: got %h exp %h", i, pc4_out, pc + 32'd4); end
            n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b exp 1", i, valid_out); end
        end
        n_cmp++; if (imem_addr_out !== 32'hC) begin n_bad++; $display("FAIL seq_addr: got %h exp %h", imem_addr_out, 32'hC); end
    endtask

    task automatic test_redirect();
        redirect_in = 1'b1; redirect_pc_in = 32'h10;
        step();
        redirect_pc_in = 32'h103;
        step();
        redirect_in = 1'b0;
        n_cmp++; if (pc_out !== 32'h10) begin n_bad++; $display("FAIL redir_slot_pc: got %h exp %h", pc_out, 32'h10); end
        n_cmp++; if (inst_out !== (32'h10 ^ XORV)) begin n_bad++; $display("FAIL redir_slot_inst: got %h exp %h", inst_out, 32'h10 ^ XORV); end
        n_cmp++; if (imem_addr_out !== 32'h100) begin n_bad++; $display("FAIL redir_addr: got %h exp %h", imem_addr_out, 32'h100); end
        step();
        n_cmp++; if (pc_out !== 32'h100) begin n_bad++; $display("FAIL redir_tgt_pc: got %h exp %h", pc_out, 32'h100); end
        n_cmp++; if (inst_out !== (32'h100 ^ XORV)) begin n_bad++; $display("FAIL redir_tgt_inst: got %h exp %h", inst_out, 32'h100 ^ XORV); end
        n_cmp++; if (pc4_out !== 32'h104) begin n_bad++; $display("FAIL redir_tgt_pc4: got %h exp %h", pc4_out, 32'h104); end
    endtask

    task automatic test_stall_redirect();
        redirect_in = 1'b1; redirect_pc_in = 32'h20;
        step();
        stall_in = 1'b1; redirect_pc_in = 32'h200;
        step();
        redirect_in = 1'b0;
        n_cmp++; if (imem_addr_out !== 32'h20) begin n_bad++; $display("FAIL stall_addr1: got %h exp %h", imem_addr_out, 32'h20); end
        n_cmp++; if (pc_out !== 32'h104) begin n_bad++; $display("FAIL stall_hold1: got %h exp %h", pc_out, 32'h104); end
        step();
        n_cmp++; if (imem_addr_out !== 32'h20) begin n_bad++; $display("FAIL stall_addr2: got %h exp %h", imem_addr_out, 32'h20); end
        n_cmp++; if (inst_out !== (32'h104 ^ XORV)) begin n_bad++; $display("FAIL stall_hold2: got %h exp %h", inst_out, 32'h104 ^ XORV); end
        stall_in = 1'b0;
        step();
        n_cmp++; if (pc_out !== 32'h20) begin n_bad++; $display("FAIL stall_slot_pc: got %h exp %h", pc_out, 32'h20); end
        n_cmp++; if (imem_addr_out !== 32'h200) begin n_bad++; $display("FAIL stall_tgt_addr: got %h exp %h", imem_addr_out, 32'h200); end
        step();
        n_cmp++; if (pc_out !== 32'h200) begin n_bad++; $display("FAIL stall_tgt_pc: got %h exp %h", pc_out, 32'h200); end
        n_cmp++; if (imem_addr_out !== 32'h204) begin n_bad++; $display("FAIL stall_pend_clr: got %h exp %h", imem_addr_out, 32'h204); end
    endtask

    task automatic test_flush_stall();
        flush_in = 1'b1; stall_in = 1'b1;
        step();
        flush_in = 1'b0; stall_in = 1'b0;
        n_cmp++; if (inst_out !== 32'h0) begin n_bad++; $display("FAIL flush_inst: got %h exp %h", inst_out, 32'h0); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b exp 0", valid_out); end
        n_cmp++; if (pc_out !== 32'h200) begin n_bad++; $display("FAIL flush_pc_hold: got %h exp %h", pc_out, 32'h200); end
        n_cmp++; if (pc4_out !== 32'h204) begin n_bad++; $display("FAIL flush_pc4_hold: got %h exp %h", pc4_out, 32'h204); end
        n_cmp++; if (imem_addr_out !== 32'h204) begin n_bad++; $display("FAIL flush_addr: got %h exp %h", imem_addr_out, 32'h204); end
        step();
        n_cmp++; if (pc_out !== 32'h204 || valid_out !== 1'b1) begin n_bad++; $display("FAIL flush_resume: got %h/%b exp %h/1", pc_out, valid_out, 32'h204); end
    endtask

    task automatic test_newest_wins();
        stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h400;
        step();
        redirect_pc_in = 32'h502;
        step();
        redirect_in = 1'b0; stall_in = 1'b0;
        step();
        n_cmp++; if (imem_addr_out !== 32'h500) begin n_bad++; $display("FAIL newest_addr: got %h exp %h", imem_addr_out, 32'h500); end
    endtask

    task automatic test_wrap();
        redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
        step();
        redirect_in = 1'b0;
        step();
        n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc: got %h exp %h", pc_out, 32'hFFFF_FFFC); end
        n_cmp++; if (pc4_out !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h exp %h", pc4_out, 32'h0); end
        n_cmp++; if (imem_addr_out !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h exp %h", imem_addr_out, 32'h0); end
        step();
        n_cmp++; if (pc_out !== 32'h0 || pc4_out !== 32'h4) begin n_bad++; $display("FAIL wrap_next: got %h/%h exp 0/4", pc_out, pc4_out); end
    endtask

    task automatic test_reset_pending();
        stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h300;
        step();
        redirect_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (inst_out !== 32'h0 || valid_out !== 1'b0) begin n_bad++; $display("FAIL rstp_inst: got %h/%b exp 0/0", inst_out, valid_out); end
        n_cmp++; if (pc_out !== 32'h0 || pc4_out !== 32'h0) begin n_bad++; $display("FAIL rstp_pc: got %h/%h exp 0/0", pc_out, pc4_out); end
        n_cmp++; if (imem_addr_out !== 32'h0) begin n_bad++; $display("FAIL rstp_addr: got %h exp %h", imem_addr_out, 32'h0); end
        stall_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++; if (pc_out !== 32'h0 || valid_out !== 1'b1) begin n_bad++; $display("FAIL rstp_first: got %h/%b exp 0/1", pc_out, valid_out); end
        n_cmp++; if (imem_addr_out !== 32'h4) begin n_bad++; $display("FAIL rstp_no_stale: got %h exp %h", imem_addr_out, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_redirect();
        test_flush_stall();
        test_newest_wins();
        test_wrap();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
